// File: rtl/syncfifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO and its benches.
package syncfifo_pkg;

    // Default geometry shared by the FIFO benches and the interface.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/syncfifo_param_if.sv
// Producer/consumer side bus of the parametrised synchronous FIFO.
interface syncfifo_param_if
    import syncfifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = clog2(DEPTH) + 1;

    logic             wn;
    logic             rn;
    logic [WIDTH-1:0] DATAIN;
    logic [WIDTH-1:0] DATAOUT;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    // FIFO side: receives requests, drives data and status.
    modport slave (
        input  wn, rn, DATAIN,
        output DATAOUT, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    // Client side: issues requests, observes data and status.
    modport master (
        output wn, rn, DATAIN,
        input  DATAOUT, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

endinterface

// File: rtl/syncfifo_mem.sv
// WIDTH x DEPTH FIFO storage: one synchronous write port and a read port
// that is registered (FWFT=0) or asynchronous (FWFT=1).
module syncfifo_mem
    import syncfifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int FWFT  = 0,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store an accepted write word; storage itself is never cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    generate
        if (FWFT != 0) begin : g_async_rd
            // Head entry is presented directly; pop and reset act on pointers only.
            logic unused_rd_ctrl;
            assign unused_rd_ctrl = rst_i ^ re_i;
            assign rdata_o        = mem_q[raddr_i];
        end else begin : g_reg_rd
            logic [WIDTH-1:0] rdata_q;
            // Load the head word on an accepted read, otherwise hold the last word.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rdata_q <= '0;
                end else if (re_i) begin
                    rdata_q <= mem_q[raddr_i];
                end
            end
            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/syncfifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags,
// overflow/underflow pulses and optional first-word-fall-through reads.
module syncfifo_param
    import syncfifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input logic             clock,
    input logic             reset,
    syncfifo_param_if.slave bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             full_w, empty_w;
    logic             rd_ok, wr_ok;
    logic [CW-1:0]    count_w;
    logic [WIDTH-1:0] rdata_w;

    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count_w = wr_ptr_q - rd_ptr_q;

    // A read needs data present; a write into a full FIFO is allowed only
    // when a read frees the slot on the same edge.
    assign rd_ok = bus.rn & ~empty_w;
    assign wr_ok = bus.wn & (~full_w | rd_ok);

    // Next-state pointers and error pulses from the pre-edge state.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = bus.wn & ~wr_ok;
        underflow_d = bus.rn & ~rd_ok;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer and error-pulse registers; reset overrides any request.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    syncfifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .FWFT  (FWFT)
    ) u_mem (
        .clk_i   (clock),
        .rst_i   (reset),
        .we_i    (wr_ok & ~reset),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (bus.DATAIN),
        .re_i    (rd_ok & ~reset),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rdata_w)
    );

    // In fall-through mode an empty FIFO shows zero rather than stale storage.
    assign bus.DATAOUT      = ((FWFT != 0) && empty_w) ? '0 : rdata_w;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.count        = count_w;
    assign bus.almost_full  = (count_w >= AF_C);
    assign bus.almost_empty = (count_w <= AE_C);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_syncfifo_param.sv
// Directed bench for syncfifo_param: registered-read and fall-through instances.
module tb_syncfifo_param;
    import syncfifo_pkg::*;

    logic clock;
    logic rst0;
    logic rst1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] vals [8];
    logic [7:0] q [$];
    logic [7:0] exp_d;
    logic [7:0] din_r;
    logic       wn_r, rn_r, m_rd, m_wr;
    int         written;

    syncfifo_param_if #(.WIDTH(DEF_WIDTH), .DEPTH(DEF_DEPTH)) if0 ();
    syncfifo_param_if #(.WIDTH(DEF_WIDTH), .DEPTH(DEF_DEPTH)) if1 ();

    syncfifo_param #(.WIDTH(DEF_WIDTH), .DEPTH(DEF_DEPTH), .FWFT(0)) dut0 (
        .clock (clock),
        .reset (rst0),
        .bus   (if0)
    );

    syncfifo_param #(.WIDTH(DEF_WIDTH), .DEPTH(DEF_DEPTH), .FWFT(1)) dut1 (
        .clock (clock),
        .reset (rst1),
        .bus   (if1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    initial begin
        vals[0] = 8'd100; vals[1] = 8'd150; vals[2] = 8'd200; vals[3] = 8'd40;
        vals[4] = 8'd70;  vals[5] = 8'd65;  vals[6] = 8'd15;  vals[7] = 8'd90;

        if0.wn = 1'b0; if0.rn = 1'b0; if0.DATAIN = '0;
        if1.wn = 1'b0; if1.rn = 1'b0; if1.DATAIN = '0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        step();
        step();
        rst0 = 1'b0;
        rst1 = 1'b0;

        chk("rst_empty", if0.empty, 1);
        chk("rst_full", if0.full, 0);
        chk("rst_count", if0.count, 0);
        chk("rst_ae", if0.almost_empty, 1);
        chk("rst_af", if0.almost_full, 0);
        chk("rst_ovf", if0.overflow, 0);
        chk("rst_unf", if0.underflow, 0);
        chk("rst_dout", if0.DATAOUT, 0);
        chk("rst1_dout", if1.DATAOUT, 0);
        chk("rst1_empty", if1.empty, 1);

        // Fill to full
        for (int i = 0; i < 8; i++) begin
            if0.wn = 1'b1;
            if0.DATAIN = vals[i];
            step();
            chk("fill_count", if0.count, i + 1);
            chk("fill_af", if0.almost_full, (i + 1 >= 7) ? 1 : 0);
            chk("fill_ae", if0.almost_empty, (i + 1 <= 1) ? 1 : 0);
        end
        chk("fill_full", if0.full, 1);
        chk("fill_empty", if0.empty, 0);

        // Write into full FIFO
        if0.DATAIN = 8'd33;
        step();
        if0.wn = 1'b0;
        chk("ovf_pulse", if0.overflow, 1);
        chk("ovf_count", if0.count, 8);
        step();
        chk("ovf_clear", if0.overflow, 0);
        chk("ovf_count2", if0.count, 8);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            if0.rn = 1'b1;
            step();
            chk("drain_data", if0.DATAOUT, vals[i]);
            chk("drain_count", if0.count, 7 - i);
        end
        chk("drain_empty", if0.empty, 1);
        step();
        if0.rn = 1'b0;
        chk("unf_pulse", if0.underflow, 1);
        chk("unf_hold", if0.DATAOUT, 90);
        step();
        chk("unf_clear", if0.underflow, 0);
        chk("unf_hold2", if0.DATAOUT, 90);

        // Refill, then simultaneous write+read at full
        for (int i = 0; i < 8; i++) begin
            if0.wn = 1'b1;
            if0.DATAIN = vals[i];
            step();
        end
        chk("refill_full", if0.full, 1);
        for (int i = 0; i < 8; i++) begin
            if0.wn = 1'b1;
            if0.rn = 1'b1;
            if0.DATAIN = 8'd7;
            step();
            chk("rw_full_count", if0.count, 8);
            chk("rw_full_ovf", if0.overflow, 0);
            chk("rw_full_data", if0.DATAOUT, vals[i]);
        end
        if0.wn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if0.rn = 1'b1;
            step();
            chk("rw_tail_data", if0.DATAOUT, 7);
        end
        chk("rw_tail_empty", if0.empty, 1);

        // Write+read on empty FIFO
        if0.wn = 1'b1;
        if0.rn = 1'b1;
        if0.DATAIN = 8'd55;
        step();
        chk("erw_unf", if0.underflow, 1);
        chk("erw_ovf", if0.overflow, 0);
        chk("erw_count", if0.count, 1);
        if0.wn = 1'b0;
        step();
        if0.rn = 1'b0;
        chk("erw_data", if0.DATAOUT, 55);
        chk("erw_count2", if0.count, 0);
        chk("erw_unf2", if0.underflow, 0);

        // Random stream against a reference queue
        q.delete();
        written = 0;
        for (int c = 0; c < 400 && written < 40; c++) begin
            wn_r  = ($urandom_range(0, 3) != 0);
            rn_r  = ($urandom_range(0, 1) != 0);
            din_r = 8'($urandom);
            if0.wn = wn_r;
            if0.rn = rn_r;
            if0.DATAIN = din_r;
            m_rd = rn_r && (q.size() != 0);
            m_wr = wn_r && ((q.size() < 8) || m_rd);
            step();
            if (m_rd) exp_d = q.pop_front();
            if (m_wr) begin
                q.push_back(din_r);
                written++;
            end
            chk("stream_count", if0.count, q.size());
            if (m_rd) chk("stream_data", if0.DATAOUT, exp_d);
            chk("stream_ovf", if0.overflow, (wn_r && !m_wr) ? 1 : 0);
            chk("stream_unf", if0.underflow, (rn_r && !m_rd) ? 1 : 0);
        end
        chk("stream_done", written, 40);

        // Bring occupancy to 5, then reset with requests pending
        for (int c = 0; c < 20 && q.size() != 5; c++) begin
            if (q.size() > 5) begin
                if0.wn = 1'b0;
                if0.rn = 1'b1;
                step();
                exp_d = q.pop_front();
                chk("adj_data", if0.DATAOUT, exp_d);
            end else begin
                if0.wn = 1'b1;
                if0.rn = 1'b0;
                if0.DATAIN = 8'($urandom);
                q.push_back(if0.DATAIN);
                step();
            end
        end
        if0.wn = 1'b0;
        if0.rn = 1'b0;
        chk("pre_rst_count", if0.count, 5);
        if0.wn = 1'b1;
        if0.rn = 1'b1;
        if0.DATAIN = 8'd99;
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        if0.wn = 1'b0;
        if0.rn = 1'b0;
        chk("mid_rst_count", if0.count, 0);
        chk("mid_rst_empty", if0.empty, 1);
        chk("mid_rst_dout", if0.DATAOUT, 0);
        chk("mid_rst_ovf", if0.overflow, 0);
        step();
        chk("mid_rst_hold", if0.count, 0);

        // First-word-fall-through instance
        if1.wn = 1'b1;
        if1.DATAIN = 8'd100;
        step();
        if1.wn = 1'b0;
        chk("fwft_head", if1.DATAOUT, 100);
        chk("fwft_count1", if1.count, 1);
        chk("fwft_nempty", if1.empty, 0);
        if1.wn = 1'b1;
        if1.DATAIN = 8'd150;
        step();
        if1.wn = 1'b0;
        chk("fwft_count2", if1.count, 2);
        chk("fwft_head2", if1.DATAOUT, 100);
        if1.rn = 1'b1;
        step();
        if1.rn = 1'b0;
        chk("fwft_pop", if1.DATAOUT, 150);
        chk("fwft_count3", if1.count, 1);
        if1.rn = 1'b1;
        step();
        if1.rn = 1'b0;
        chk("fwft_empty", if1.empty, 1);
        chk("fwft_count4", if1.count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/syncfifo_param.md
# syncfifo_param

Parametrised single-clock FIFO: the next generation of the team's fixed 8-bit synchronous FIFO. Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses and an optional first-word-fall-through (FWFT) read mode. It sits between any producer and consumer in the same clock domain, such as the UART and packet datapaths, and replaces the fixed FIFO wherever depth or flags matter.

## Interface
- WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 8: number of entries; a power of two, ≥2.
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL.
- FWFT, 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
- wn  in  1  write request.
- rn  in  1  read request.
- DATAIN  in  WIDTH  write data, sampled on an accepted write.
- DATAOUT  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

## Operation
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide. The MSB is the wrap bit and the low bits address memory.
  - full = (low bits equal) and (MSB differs).
  - empty = (pointers equal).
  - count = wr_ptr − rd_ptr, modulo 2^(AW+1).
- Accept rules, evaluated at the rising edge with pre-edge state:
  - rd_ok = rn & !empty.
  - wr_ok = wn & (!full | rd_ok).
  - A write to a full FIFO with a simultaneous accepted read is accepted. count stays at DEPTH.
  - A read from an empty FIFO with a simultaneous write is rejected in both modes. The write is accepted and count becomes 1.
- Pointer updates: wr_ok increments wr_ptr and writes DATAIN to mem[wr_ptr]. rd_ok increments rd_ptr. Both pointers wrap naturally at 2^(AW+1).
- overflow is registered as wn & !wr_ok. underflow is registered as rn & !rd_ok. Each is high for exactly the cycle after the offending edge.
- FWFT=0: on rd_ok, DATAOUT is loaded with mem[rd_ptr] at that edge. Otherwise DATAOUT holds its last value.
- FWFT=1: DATAOUT continuously shows mem[rd_ptr], the head entry, and is valid whenever empty=0. rd_ok pops the head, and DATAOUT shows the next entry after the edge. When empty=1, DATAOUT is don't-care.
- Flags and count are registered, or derived from registered pointers. There is no combinational path from wn/rn to any output.

## Timing
- Reset applies at the edge where reset=1 and overrides wn/rn at that edge. After it:
  - pointers = 0, count = 0;
  - empty = 1, full = 0;
  - almost_empty = 1, almost_full = (AF_LEVEL == 0);
  - overflow = underflow = 0;
  - DATAOUT = 0.
- Reset mid-operation discards all contents. Memory contents are not cleared and are not observable.
- Write-to-flag latency is 1 cycle: empty, count and the almost flags reflect a write after the same edge that accepts it.
- Read latency:
  - FWFT=0: data appears on DATAOUT after the accepting edge, i.e. 1 cycle.
  - FWFT=1: 0 cycles; the head is presented before the read.
- Sustained throughput is one write and one read per cycle with no bubbles, including at full and at empty+write.
- Depth wrap-around has no effect on data order or flags.

## Structure
- Shared package/header syncfifo_pkg:
  - a clog2 helper constant function;
  - a default WIDTH/DEPTH localparam pair reused by the FIFO benches.
- One sub-module, syncfifo_mem:
  - WIDTH×DEPTH storage with one synchronous write port;
  - a read port that is registered when FWFT=0 and asynchronous when FWFT=1.
- Pointer, flag and error logic live in syncfifo_param.

## Test plan
All scenarios use DEPTH=8 and WIDTH=8.
- Reset then write 100,150,200,40,70,65,15,90 -> full=1, count=8, almost_full=1 from count 7. A 9th write of 33 -> overflow pulses for 1 cycle, count stays 8.
- FWFT=0: read 8 times -> DATAOUT is 100,150,...,90, each one cycle after its rn edge, and empty=1 after the 8th. A 9th read -> underflow pulses and DATAOUT holds 90.
- Full FIFO, wn=rn=1 with DATAIN=7 for 8 cycles -> count stays 8, no overflow. The following reads return 100..90 in order, then 7 ×8 (eight times).
- Empty FIFO, wn=rn=1 with DATAIN=55 -> write accepted, read rejected, underflow=1, count=1. The next rn returns 55.
- FWFT=1: write 100 -> DATAOUT=100 one cycle later with no rn. Write 150 then pulse rn -> DATAOUT=150 after the edge, count=1.
- Wrap and reset: stream 40 words with random wn/rn against a reference queue -> no mismatch and count always matches. Assert reset while count=5 -> count=0, empty=1, DATAOUT=0 on the next cycle.
